// File: rtl/fill_pkg.sv
// Shared types and helpers for the fill beat streamer.
// Define FILL_BEAT_STREAMER_XZ_EN to make the X and Z fill kinds legal (simulation builds only).
package fill_pkg;

  typedef enum logic [2:0] {
    FILL_ZERO = 3'd0,
    FILL_ONE  = 3'd1,
    FILL_X    = 3'd2,
    FILL_Z    = 3'd3,
    FILL_PAT  = 3'd4
  } fill_kind_e;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StStream = 1'b1
  } fill_state_e;

  // Kinds 5-7 are never legal; X/Z only when the 4-state build is enabled.
  function automatic logic kind_legal(logic [2:0] kind);
`ifdef FILL_BEAT_STREAMER_XZ_EN
    return kind <= 3'd4;
`else
    return (kind == 3'd0) || (kind == 3'd1) || (kind == 3'd4);
`endif
  endfunction

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(int unsigned value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/fill_beat_streamer_if.sv
// Command and beat-stream signals of the fill beat streamer.
// master = command source / beat sink, slave = the streamer itself.
interface fill_beat_streamer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned PAT_W  = 4
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_kind;
  logic [LEN_W-1:0]  cmd_len;
  logic [PAT_W-1:0]  cmd_pattern;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] out_mask;
  logic              out_last;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_kind, cmd_len, cmd_pattern, out_ready,
    input  cmd_ready, out_valid, out_data, out_mask, out_last, done, err
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_len, cmd_pattern, out_ready,
    output cmd_ready, out_valid, out_data, out_mask, out_last, done, err
  );

endinterface

// File: rtl/fill_pattern_rot.sv
// Replicates a PAT_W-bit pattern across one beat starting at a given phase,
// zeroing every bit at or above the valid bit count.
module fill_pattern_rot
  import fill_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned PhaseW = clog2_min1(PAT_W),
  parameter int unsigned CntW   = $clog2(DATA_W + 1)
) (
  input  logic [PAT_W-1:0]  pattern_i,
  input  logic [PhaseW-1:0] phase_i,
  input  logic [CntW-1:0]   count_i,
  output logic [DATA_W-1:0] data_o
);

  logic [PhaseW-1:0] idx;

  always_comb begin
    data_o = '0;
    idx    = '0;
    for (int unsigned j = 0; j < DATA_W; j++) begin
      idx = PhaseW'((32'(phase_i) + j) % PAT_W);
      if (CntW'(j) < count_i) begin
        data_o[j] = pattern_i[idx];
      end
    end
  end

endmodule

// File: rtl/fill_beat_streamer.sv
// Expands one fill command (zeros/ones/X/Z/repeating pattern over a bit length) into DATA_W-bit
// beats on a valid/ready stream. FILL_BEAT_STREAMER_XZ_EN enables literal X/Z fills.
module fill_beat_streamer
  import fill_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned PAT_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fill_beat_streamer_if.slave bus
);

  localparam int unsigned PhaseW    = clog2_min1(PAT_W);
  localparam int unsigned CntW      = $clog2(DATA_W + 1);
  localparam int unsigned CmpW      = (LEN_W > 32) ? LEN_W : 32;
  localparam int unsigned PhaseStep = DATA_W % PAT_W;

  fill_state_e       state_q, state_d;
  fill_kind_e        kind_q, kind_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] out_mask_q, out_mask_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              load;
  logic              clear;
  logic [PhaseW:0]   phase_sum;
  logic [CntW-1:0]   cur_n;
  logic [CntW-1:0]   beat_n;
  logic              beat_last;
  logic [DATA_W-1:0] beat_mask;
  logic [DATA_W-1:0] beat_data;
  logic [DATA_W-1:0] rot_data;

  function automatic logic [CntW-1:0] beat_count(logic [LEN_W-1:0] rem);
    if (CmpW'(rem) >= CmpW'(DATA_W)) begin
      return CntW'(DATA_W);
    end
    return CntW'(rem);
  endfunction

  // Control: command acceptance, per-beat bookkeeping and completion pulses.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    pat_d       = pat_q;
    rem_d       = rem_q;
    phase_d     = phase_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    load        = 1'b0;
    clear       = 1'b0;
    cur_n       = beat_count(rem_q);
    phase_sum   = {1'b0, phase_q} + (PhaseW + 1)'(PhaseStep);
    if (phase_sum >= (PhaseW + 1)'(PAT_W)) begin
      phase_sum = phase_sum - (PhaseW + 1)'(PAT_W);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          if (!kind_legal(bus.cmd_kind)) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (bus.cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            kind_d      = fill_kind_e'(bus.cmd_kind);
            pat_d       = bus.cmd_pattern;
            rem_d       = bus.cmd_len;
            phase_d     = '0;
            state_d     = StStream;
            out_valid_d = 1'b1;
            load        = 1'b1;
          end
        end
      end
      StStream: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            clear       = 1'b1;
          end else begin
            rem_d   = rem_q - LEN_W'(cur_n);
            phase_d = phase_sum[PhaseW-1:0];
            load    = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  fill_pattern_rot #(
    .DATA_W (DATA_W),
    .PAT_W  (PAT_W),
    .PhaseW (PhaseW),
    .CntW   (CntW)
  ) u_rot (
    .pattern_i (pat_d),
    .phase_i   (phase_d),
    .count_i   (beat_n),
    .data_o    (rot_data)
  );

  // Contents of the beat that will be presented after the next edge.
  always_comb begin
    beat_n    = beat_count(rem_d);
    beat_last = CmpW'(rem_d) <= CmpW'(DATA_W);
    beat_mask = '0;
    for (int unsigned j = 0; j < DATA_W; j++) begin
      beat_mask[j] = CntW'(j) < beat_n;
    end
    beat_data = '0;
    unique case (kind_d)
      FILL_ONE: beat_data = beat_mask;
`ifdef FILL_BEAT_STREAMER_XZ_EN
      FILL_X: begin
        for (int unsigned j = 0; j < DATA_W; j++) begin
          if (beat_mask[j]) beat_data[j] = 1'bx;
        end
      end
      FILL_Z: begin
        for (int unsigned j = 0; j < DATA_W; j++) begin
          if (beat_mask[j]) beat_data[j] = 1'bz;
        end
      end
`endif
      FILL_PAT: beat_data = rot_data;
      default:  beat_data = '0;
    endcase
  end

  // Output registers only change on a load or on retiring the last beat, so stalls hold them.
  always_comb begin
    out_data_d = out_data_q;
    out_mask_d = out_mask_q;
    out_last_d = out_last_q;
    if (load) begin
      out_data_d = beat_data;
      out_mask_d = beat_mask;
      out_last_d = beat_last;
    end else if (clear) begin
      out_data_d = '0;
      out_mask_d = '0;
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      kind_q      <= FILL_ZERO;
      pat_q       <= '0;
      rem_q       <= '0;
      phase_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      pat_q       <= pat_d;
      rem_q       <= rem_d;
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_fill_beat_streamer.sv
// Drives two streamers (PAT_W=4 and PAT_W=3) with identical commands and checks every beat
// against a bit-position model of the fill.
module tb_fill_beat_streamer;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_kind = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [3:0]    cmd_pat = '0;
  logic          out_ready = 1'b1;

  int total = 0;
  int bad = 0;

  fill_beat_streamer_if #(.DATA_W(DW), .LEN_W(LW), .PAT_W(4)) if4 ();
  fill_beat_streamer_if #(.DATA_W(DW), .LEN_W(LW), .PAT_W(3)) if3 ();

  assign if4.cmd_valid   = cmd_valid;
  assign if4.cmd_kind    = cmd_kind;
  assign if4.cmd_len     = cmd_len;
  assign if4.cmd_pattern = cmd_pat;
  assign if4.out_ready   = out_ready;
  assign if3.cmd_valid   = cmd_valid;
  assign if3.cmd_kind    = cmd_kind;
  assign if3.cmd_len     = cmd_len;
  assign if3.cmd_pattern = cmd_pat[2:0];
  assign if3.out_ready   = out_ready;

  fill_beat_streamer #(.DATA_W(DW), .LEN_W(LW), .PAT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  fill_beat_streamer #(.DATA_W(DW), .LEN_W(LW), .PAT_W(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3.slave)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [DW-1:0] obs,
                            input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(int kind);
`ifdef FILL_BEAT_STREAMER_XZ_EN
    return kind <= 4;
`else
    return (kind == 0) || (kind == 1) || (kind == 4);
`endif
  endfunction

  function automatic logic [DW-1:0] model_mask(int len, int beat);
    int n;
    n = len - beat * int'(DW);
    if (n > int'(DW)) n = DW;
    model_mask = '0;
    for (int j = 0; j < n; j++) model_mask[j] = 1'b1;
  endfunction

  // Bit j of beat b is fill bit b*DW+j of the whole run.
  function automatic logic [DW-1:0] model_data(int kind, int len, int pat, int patw, int beat);
    logic [DW-1:0] m;
    m = model_mask(len, beat);
    model_data = '0;
    for (int j = 0; j < int'(DW); j++) begin
      if (m[j]) begin
        case (kind)
          1:       model_data[j] = 1'b1;
          2:       model_data[j] = 1'bx;
          3:       model_data[j] = 1'bz;
          4:       model_data[j] = 1'((pat >> ((beat * int'(DW) + j) % patw)) & 1);
          default: model_data[j] = 1'b0;
        endcase
      end
    end
  endfunction

  task automatic run(input int kind, input int len, input int pat, input int stall);
    int  nb;
    int  idx;
    bit  lg;
    bit  ended;
    lg = model_legal(kind);
    nb = (lg && len > 0) ? (len + int'(DW) - 1) / int'(DW) : 0;
    @(negedge clk);
    check_bit("cmd_ready4", if4.cmd_ready, 1'b1);
    check_bit("cmd_ready3", if3.cmd_ready, 1'b1);
    out_ready = ($urandom_range(0, 99) >= stall);
    cmd_valid = 1'b1;
    cmd_kind  = 3'(kind);
    cmd_len   = LW'(len);
    cmd_pat   = 4'(pat);
    @(negedge clk);
    cmd_valid = 1'b0;
    idx = 0;
    ended = 0;
    for (int cyc = 0; cyc < nb * 40 + 10; cyc++) begin
      check_bit("valid4", if4.out_valid, idx < nb);
      check_bit("valid3", if3.out_valid, idx < nb);
      if (idx < nb) begin
        check_word("data4", if4.out_data, model_data(kind, len, pat & 15, 4, idx));
        check_word("data3", if3.out_data, model_data(kind, len, pat & 7, 3, idx));
        check_word("mask4", if4.out_mask, model_mask(len, idx));
        check_word("mask3", if3.out_mask, model_mask(len, idx));
        check_bit("last4", if4.out_last, idx == nb - 1);
        check_bit("last3", if3.out_last, idx == nb - 1);
        check_bit("done_early", if4.done, 1'b0);
        out_ready = ($urandom_range(0, 99) >= stall);
        if (out_ready) idx++;
      end else begin
        check_bit("done4", if4.done, 1'b1);
        check_bit("done3", if3.done, 1'b1);
        check_bit("err4", if4.err, !lg);
        check_bit("err3", if3.err, !lg);
        ended = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ended) begin
      total++;
      bad++;
      $error("FAIL timeout: observed beats=%0d expected beats=%0d with done", idx, nb);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_bit("done_pulse", if4.done, 1'b0);
    check_bit("err_pulse", if4.err, 1'b0);
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clk);
    check_bit("rst_ready", if4.cmd_ready, 1'b1);
    check_bit("rst_valid", if4.out_valid, 1'b0);
    check_word("rst_data", if4.out_data, '0);
    check_word("rst_mask", if4.out_mask, '0);
    check_bit("rst_last", if4.out_last, 1'b0);
    check_bit("rst_done", if4.done, 1'b0);
    check_bit("rst_err", if4.err, 1'b0);
    rst_n = 1'b1;

    run(1, 70, 0, 0);
    run(4, 40, 4'b1000, 0);
    run(4, 64, 4'b0001, 0);
    run(0, 0, 0, 0);
    run(6, 50, 0, 0);
    run(3, 10, 0, 0);
    run(0, 100, 0, 50);
    run(1, 32, 0, 0);
    run(4, 33, 4'b0110, 20);
    run(1, 65535, 0, 0);

    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 7);
      if (k > 4 && $urandom_range(0, 3) != 0) k = 4;
      run(k, $urandom_range(0, 300), $urandom_range(0, 15), $urandom_range(0, 60));
    end

    // Abandon a 5-beat fill while beat 2 is on the bus.
    @(negedge clk);
    out_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_kind  = 3'd1;
    cmd_len   = LW'(160);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_bit("abort_beat1", if4.out_valid, 1'b1);
    @(negedge clk);
    check_word("abort_beat2", if4.out_mask, 32'hFFFF_FFFF);
    rst_n = 1'b0;
    #1;
    check_bit("abort_valid4", if4.out_valid, 1'b0);
    check_bit("abort_valid3", if3.out_valid, 1'b0);
    check_word("abort_data", if4.out_data, '0);
    check_word("abort_mask", if4.out_mask, '0);
    check_bit("abort_last", if4.out_last, 1'b0);
    check_bit("abort_ready", if4.cmd_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("abort_nodone", if4.done, 1'b0);
    end
    rst_n = 1'b1;
    run(4, 97, $urandom_range(0, 15), 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
